// File: rtl/homelab_pkg.sv
// Shared definitions for the PS/2 keyboard front end: frame FSM states,
// scan-code constants, the list of non-key codes and the helper functions
// used by the decoder.
package homelab_pkg;

    // Default number of agreeing samples before a new PS2_CLK level is taken
    localparam int PS2_FILT_LEN_DEF = 8;
    // Default abandon time for a partial frame, 1 ms at 12 MHz
    localparam int PS2_TIMEOUT_DEF  = 12000;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Prefix bytes
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_EXT1  = 8'hE1;

    // Keyboard status/acknowledge bytes that never describe a key
    localparam int PS2_NUM_DISCARD = 6;
    localparam logic [7:0] PS2_DISCARD [PS2_NUM_DISCARD] =
        '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    // True when the byte is one of the status/acknowledge codes
    function automatic logic ps2_is_discard(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
            if (code == PS2_DISCARD[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic ps2_odd_weight(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one raw PS/2 line into the CLK12 domain. Always a two-flop
// synchronizer; optionally followed by an agreement filter that only takes a
// new level after FILT_LEN consecutive samples disagree with the current one.
module ps2_line_filter
    import homelab_pkg::*;
#(
    parameter int FILT_LEN  = PS2_FILT_LEN_DEF,
    parameter bit FILTER_EN = 1'b1
) (
    input  logic CLK12,
    input  logic RESET,
    input  logic raw_line,
    output logic clean_line
);

    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer, idles high like the bus
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= raw_line;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (FILTER_EN) begin : g_filter
            localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

            logic [CW-1:0] agree_cnt_r;
            logic          level_r;

            // Accept a new level only after FILT_LEN consecutive differing samples
            always_ff @(posedge CLK12) begin
                if (RESET) begin
                    agree_cnt_r <= {CW{1'b0}};
                    level_r     <= 1'b1;
                end else if (sync2_r == level_r) begin
                    agree_cnt_r <= {CW{1'b0}};
                    level_r     <= level_r;
                end else if (agree_cnt_r == CNT_MAX) begin
                    agree_cnt_r <= {CW{1'b0}};
                    level_r     <= sync2_r;
                end else begin
                    agree_cnt_r <= agree_cnt_r + CW'(1);
                    level_r     <= level_r;
                end
            end

            assign clean_line = level_r;
        end else begin : g_bypass
            assign clean_line = sync2_r;
        end
    endgenerate

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filters the bus, assembles 11-bit frames, checks
// start/parity/stop, and folds E0/E1/F0 prefixes into one key event per key.
module ps2_key_decoder
    import homelab_pkg::*;
#(
    parameter int FILT_LEN = PS2_FILT_LEN_DEF,
    parameter int TIMEOUT  = PS2_TIMEOUT_DEF
) (
    input  logic       CLK12,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       KEY_STROBE,
    output logic       KEY_PRESSED,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       FRAME_ERR
);

    localparam logic [13:0] TMO_LIMIT = 14'(TIMEOUT);

    logic       clk_filt_s;
    logic       data_sync_s;
    logic       clk_prev_r;
    logic       fall_s;
    logic       timeout_s;
    logic       byte_ok_s;

    ps2_state_e state_r, state_nxt;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt;
    logic [7:0]  shift_r, shift_nxt;
    logic        parity_r, parity_nxt;
    logic [13:0] tmo_cnt_r, tmo_cnt_nxt;
    logic        brk_r, brk_nxt;
    logic        ext_r, ext_nxt;
    logic        key_strobe_r, key_strobe_nxt;
    logic        key_pressed_r, key_pressed_nxt;
    logic [7:0]  key_code_r, key_code_nxt;
    logic        key_ext_r, key_ext_nxt;
    logic        frame_err_r, frame_err_nxt;

    ps2_line_filter #(
        .FILT_LEN  (FILT_LEN),
        .FILTER_EN (1'b1)
    ) u_clk_filter (
        .CLK12      (CLK12),
        .RESET      (RESET),
        .raw_line   (PS2_CLK),
        .clean_line (clk_filt_s)
    );

    // Data only needs synchronizing: it is sampled long after it settles
    ps2_line_filter #(
        .FILT_LEN  (FILT_LEN),
        .FILTER_EN (1'b0)
    ) u_data_sync (
        .CLK12      (CLK12),
        .RESET      (RESET),
        .raw_line   (PS2_DATA),
        .clean_line (data_sync_s)
    );

    // Previous filtered clock level for falling-edge detection
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            clk_prev_r <= 1'b1;
        end else begin
            clk_prev_r <= clk_filt_s;
        end
    end

    assign fall_s    = clk_prev_r & ~clk_filt_s;
    assign timeout_s = (state_r != IDLE) & ~fall_s & (tmo_cnt_r >= TMO_LIMIT);

    // Frame state, protocol flags and registered outputs
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            parity_r      <= 1'b0;
            tmo_cnt_r     <= 14'd0;
            brk_r         <= 1'b0;
            ext_r         <= 1'b0;
            key_strobe_r  <= 1'b0;
            key_pressed_r <= 1'b0;
            key_code_r    <= 8'h00;
            key_ext_r     <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt;
            bit_cnt_r     <= bit_cnt_nxt;
            shift_r       <= shift_nxt;
            parity_r      <= parity_nxt;
            tmo_cnt_r     <= tmo_cnt_nxt;
            brk_r         <= brk_nxt;
            ext_r         <= ext_nxt;
            key_strobe_r  <= key_strobe_nxt;
            key_pressed_r <= key_pressed_nxt;
            key_code_r    <= key_code_nxt;
            key_ext_r     <= key_ext_nxt;
            frame_err_r   <= frame_err_nxt;
        end
    end

    // Frame sequencing, timeout and prefix handling
    always_comb begin
        state_nxt       = state_r;
        bit_cnt_nxt     = bit_cnt_r;
        shift_nxt       = shift_r;
        parity_nxt      = parity_r;
        tmo_cnt_nxt     = tmo_cnt_r;
        brk_nxt         = brk_r;
        ext_nxt         = ext_r;
        key_strobe_nxt  = 1'b0;
        key_pressed_nxt = key_pressed_r;
        key_code_nxt    = key_code_r;
        key_ext_nxt     = key_ext_r;
        frame_err_nxt   = 1'b0;
        byte_ok_s       = 1'b0;

        // Time since the last bus clock edge, only meaningful mid-frame
        if ((state_r == IDLE) || fall_s) begin
            tmo_cnt_nxt = 14'd0;
        end else if (tmo_cnt_r != 14'h3FFF) begin
            tmo_cnt_nxt = tmo_cnt_r + 14'd1;
        end else begin
            tmo_cnt_nxt = tmo_cnt_r;
        end

        if (timeout_s) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = 3'd0;
            shift_nxt     = 8'h00;
            frame_err_nxt = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s && !data_sync_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                        shift_nxt   = 8'h00;
                    end else if (fall_s) begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    if (fall_s) begin
                        shift_nxt   = {data_sync_s, shift_r[7:1]};
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_nxt = PARITY;
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        state_nxt = DATA;
                    end
                end
                PARITY: begin
                    if (fall_s) begin
                        parity_nxt = data_sync_s;
                        state_nxt  = STOP;
                    end else begin
                        state_nxt = PARITY;
                    end
                end
                STOP: begin
                    if (fall_s) begin
                        state_nxt = IDLE;
                        if (data_sync_s && ps2_odd_weight(shift_r, parity_r)) begin
                            byte_ok_s = 1'b1;
                        end else begin
                            frame_err_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = STOP;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = 3'd0;
                end
            endcase
        end

        // Protocol layer: prefixes set flags, real codes emit one event
        if (byte_ok_s) begin
            if (shift_r == PS2_BREAK) begin
                brk_nxt = 1'b1;
                ext_nxt = ext_r;
            end else if ((shift_r == PS2_EXT) || (shift_r == PS2_EXT1)) begin
                brk_nxt = brk_r;
                ext_nxt = 1'b1;
            end else if (ps2_is_discard(shift_r)) begin
                brk_nxt = brk_r;
                ext_nxt = ext_r;
            end else begin
                key_strobe_nxt  = 1'b1;
                key_code_nxt    = shift_r;
                key_pressed_nxt = ~brk_r;
                key_ext_nxt     = ext_r;
                brk_nxt         = 1'b0;
                ext_nxt         = 1'b0;
            end
        end else if (frame_err_nxt) begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
        end else begin
            brk_nxt = brk_r;
            ext_nxt = ext_r;
        end
    end

    assign KEY_STROBE   = key_strobe_r;
    assign KEY_PRESSED  = key_pressed_r;
    assign KEY_CODE     = key_code_r;
    assign KEY_EXTENDED = key_ext_r;
    assign FRAME_ERR    = frame_err_r;

endmodule
